// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART link: received word, valid/ready handshake,
// per-frame error pulses and a state view for checkers.
interface uart_rx_if #(
    parameter int DATA_BITS = 7
);
    // rx_data is a word offered by the receiver; it is taken at a rising edge where
    // rx_valid and rx_ready are both high. rx_data stays stable while rx_valid is high,
    // and rx_ready has no effect while rx_valid is low.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
    logic [1:0]           state_dbg;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy, state_dbg,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy, state_dbg,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit, idle high.
// Each bit is sampled once at its middle cycle; stop handling returns to IDLE at once.
module uart_rx #(
    parameter int DATA_BITS    = 7,
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       rx_line,
    uart_rx_if.master  rx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rx_s = rx_line;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            always_comb sync_d = (sync_q << 1) | SYNC_STAGES'(rx_line);
            always_ff @(posedge clk) begin
                if (!nRST) sync_q <= '1;
                else       sync_q <= sync_d;
            end
            assign rx_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (valid_q && rx.rx_ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    bit_idx_d = '0;
                    if (CLKS_PER_BIT == 1) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
            end
            START: begin
                if (cnt_q == MID && rx_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                // DATA_BITS >= 2 assumed by this slice.
                if (cnt_q == MID) shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == BW'(DATA_BITS - 1)) state_d = STOP;
                    else bit_idx_d = bit_idx_q + BW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == MID) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || rx.rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;
    assign rx.busy      = (state_q != IDLE);
    assign rx.state_dbg = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver at 1 clk/bit, one at 16 clks/bit.
module tb_uart_rx;
  logic clk;
  logic nRST;
  logic rx_line1;
  logic rx_line16;

  int tests;
  int fails;

  uart_rx_if #(.DATA_BITS(7)) if1 ();
  uart_rx_if #(.DATA_BITS(7)) if16 ();

  uart_rx #(.DATA_BITS(7), .CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .nRST(nRST), .rx_line(rx_line1), .rx(if1)
  );
  uart_rx #(.DATA_BITS(7), .CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .nRST(nRST), .rx_line(rx_line16), .rx(if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: accepted words and flag pulses per receiver
  logic [6:0] got_q1[$];
  logic [6:0] got_q16[$];
  int vcyc1, fe1, ov1, vcyc16, fe16, ov16;
  logic both_seen;

  initial begin
    vcyc1 = 0; fe1 = 0; ov1 = 0; vcyc16 = 0; fe16 = 0; ov16 = 0; both_seen = 1'b0;
  end

  always @(negedge clk) begin
    if (nRST) begin
      if (if1.rx_valid) vcyc1++;
      if (if1.rx_valid && if1.rx_ready) got_q1.push_back(if1.rx_data);
      if (if1.frame_err) fe1++;
      if (if1.overrun) ov1++;
      if (if16.rx_valid) vcyc16++;
      if (if16.rx_valid && if16.rx_ready) got_q16.push_back(if16.rx_data);
      if (if16.frame_err) fe16++;
      if (if16.overrun) ov16++;
      if ((if1.frame_err && if1.overrun) || (if16.frame_err && if16.overrun)) both_seen = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx_line1 = v;
    else rx_line16 = v;
  endtask

  task automatic send_frame(input int sel, input logic [6:0] d, input logic stop_bit,
                            input int start_len);
    int cpb;
    cpb = (sel == 0) ? 1 : 16;
    drive(sel, 1'b0);
    tick(start_len);
    for (int i = 0; i < 7; i++) begin
      drive(sel, d[i]);
      tick(cpb);
    end
    drive(sel, stop_bit);
    tick(cpb);
    drive(sel, 1'b1);
  endtask

  task automatic test_reset();
    int fe0, ov0;
    nRST = 1'b0; rx_line1 = 1'b1; rx_line16 = 1'b1;
    if1.rx_ready = 1'b0; if16.rx_ready = 1'b0;
    tick(3);
    nRST = 1'b1;
    fe0 = fe1; ov0 = ov1;
    tick(20);
    tests++; if (if1.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", if1.rx_valid); end
    tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", if1.busy); end
    tests++; if (if1.rx_data !== 7'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", if1.rx_data); end
    tests++; if (fe1 - fe0 !== 0 || ov1 - ov0 !== 0) begin fails++; $display("FAIL reset_flags: got fe=%0d ov=%0d expected 0 0", fe1 - fe0, ov1 - ov0); end
    tests++; if (if16.busy !== 1'b0 || if16.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_dut16: got busy=%b valid=%b expected 0 0", if16.busy, if16.rx_valid); end
  endtask

  task automatic test_basic();
    int g0, v0, fe0, ov0;
    if1.rx_ready = 1'b1;
    g0 = got_q1.size(); v0 = vcyc1; fe0 = fe1; ov0 = ov1;
    send_frame(0, 7'h2A, 1'b1, 1);
    tick(10);
    tests++; if (got_q1.size() - g0 !== 1) begin fails++; $display("FAIL basic_count: got %0d words expected 1", got_q1.size() - g0); end
    else begin
      tests++; if (got_q1[got_q1.size()-1] !== 7'h2A) begin fails++; $display("FAIL basic_data: got %h expected 2a", got_q1[got_q1.size()-1]); end
    end
    tests++; if (vcyc1 - v0 !== 1) begin fails++; $display("FAIL basic_valid_len: got %0d cycles expected 1", vcyc1 - v0); end
    tests++; if (fe1 - fe0 !== 0 || ov1 - ov0 !== 0) begin fails++; $display("FAIL basic_flags: got fe=%0d ov=%0d expected 0 0", fe1 - fe0, ov1 - ov0); end
  endtask

  task automatic test_back_to_back();
    int g0, fe0, ov0;
    if1.rx_ready = 1'b0;
    fe0 = fe1; ov0 = ov1;
    send_frame(0, 7'h7F, 1'b1, 1);
    send_frame(0, 7'h00, 1'b1, 1);
    tick(10);
    tests++; if (if1.rx_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b expected 1", if1.rx_valid); end
    tests++; if (if1.rx_data !== 7'h7F) begin fails++; $display("FAIL b2b_data: got %h expected 7f", if1.rx_data); end
    tests++; if (ov1 - ov0 !== 1) begin fails++; $display("FAIL b2b_overrun: got %0d pulses expected 1", ov1 - ov0); end
    tests++; if (fe1 - fe0 !== 0) begin fails++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", fe1 - fe0); end
    g0 = got_q1.size();
    if1.rx_ready = 1'b1;
    tick(2);
    tests++; if (got_q1.size() - g0 !== 1) begin fails++; $display("FAIL b2b_drain_count: got %0d words expected 1", got_q1.size() - g0); end
    else begin
      tests++; if (got_q1[got_q1.size()-1] !== 7'h7F) begin fails++; $display("FAIL b2b_drain_data: got %h expected 7f", got_q1[got_q1.size()-1]); end
    end
    tests++; if (if1.rx_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b expected 0", if1.rx_valid); end
  endtask

  task automatic test_frame_err();
    int g0, v0, fe0, ov0;
    if1.rx_ready = 1'b1;
    v0 = vcyc1; fe0 = fe1; ov0 = ov1;
    send_frame(0, 7'h55, 1'b0, 1);
    tick(6);
    tests++; if (fe1 - fe0 !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d pulses expected 1", fe1 - fe0); end
    tests++; if (vcyc1 - v0 !== 0) begin fails++; $display("FAIL ferr_valid: got %0d valid cycles expected 0", vcyc1 - v0); end
    tests++; if (ov1 - ov0 !== 0) begin fails++; $display("FAIL ferr_overrun: got %0d pulses expected 0", ov1 - ov0); end
    g0 = got_q1.size();
    send_frame(0, 7'h11, 1'b1, 1);
    tick(10);
    tests++; if (got_q1.size() - g0 !== 1) begin fails++; $display("FAIL ferr_next_count: got %0d words expected 1", got_q1.size() - g0); end
    else begin
      tests++; if (got_q1[got_q1.size()-1] !== 7'h11) begin fails++; $display("FAIL ferr_next_data: got %h expected 11", got_q1[got_q1.size()-1]); end
    end
  endtask

  task automatic test_oversample();
    int g0, v0, fe0, ov0;
    if16.rx_ready = 1'b1;
    v0 = vcyc16; fe0 = fe16; ov0 = ov16;
    drive(1, 1'b0);
    tick(1);
    drive(1, 1'b1);
    tick(40);
    tests++; if (vcyc16 - v0 !== 0 || fe16 - fe0 !== 0 || ov16 - ov0 !== 0) begin fails++; $display("FAIL glitch: got valid=%0d fe=%0d ov=%0d expected 0 0 0", vcyc16 - v0, fe16 - fe0, ov16 - ov0); end
    tests++; if (if16.busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", if16.busy); end
    g0 = got_q16.size();
    send_frame(1, 7'h3C, 1'b1, 16);
    tick(40);
    send_frame(1, 7'h3C, 1'b1, 22);
    tick(40);
    send_frame(1, 7'h3C, 1'b1, 10);
    tick(40);
    tests++; if (got_q16.size() - g0 !== 3) begin fails++; $display("FAIL os_count: got %0d words expected 3", got_q16.size() - g0); end
    else begin
      tests++; if (got_q16[g0] !== 7'h3C) begin fails++; $display("FAIL os_clean: got %h expected 3c", got_q16[g0]); end
      tests++; if (got_q16[g0+1] !== 7'h3C) begin fails++; $display("FAIL os_skew_late: got %h expected 3c", got_q16[g0+1]); end
      tests++; if (got_q16[g0+2] !== 7'h3C) begin fails++; $display("FAIL os_skew_early: got %h expected 3c", got_q16[g0+2]); end
    end
    tests++; if (fe16 - fe0 !== 0) begin fails++; $display("FAIL os_frame_err: got %0d pulses expected 0", fe16 - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [6:0] w;
    if1.rx_ready = 1'b0;
    send_frame(0, 7'h33, 1'b1, 1);
    tick(10);
    tests++; if (if1.rx_valid !== 1'b1 || if1.rx_data !== 7'h33) begin fails++; $display("FAIL rst_preload: got valid=%b data=%h expected 1 33", if1.rx_valid, if1.rx_data); end
    w = 7'h2A;
    drive(0, 1'b0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      drive(0, w[i]);
      tick(1);
    end
    tests++; if (if1.busy !== 1'b1) begin fails++; $display("FAIL rst_busy_before: got %b expected 1", if1.busy); end
    nRST = 1'b0;
    tick(1);
    nRST = 1'b1;
    drive(0, 1'b1);
    tests++; if (if1.rx_valid !== 1'b0 || if1.rx_data !== 7'h00) begin fails++; $display("FAIL rst_outputs: got valid=%b data=%h expected 0 00", if1.rx_valid, if1.rx_data); end
    tests++; if (if1.busy !== 1'b0 || if1.frame_err !== 1'b0 || if1.overrun !== 1'b0) begin fails++; $display("FAIL rst_status: got busy=%b fe=%b ov=%b expected 0 0 0", if1.busy, if1.frame_err, if1.overrun); end
    tick(5);
    if1.rx_ready = 1'b1;
    send_frame(0, 7'h05, 1'b1, 1);
    tick(10);
    tests++; if (if1.rx_data !== 7'h05) begin fails++; $display("FAIL rst_next_data: got %h expected 05", if1.rx_data); end
    tests++; if (got_q1.size() == 0 || got_q1[got_q1.size()-1] !== 7'h05) begin fails++; $display("FAIL rst_next_accept: last accepted word is not 05"); end
    tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL flag_exclusive: got frame_err and overrun together, expected never"); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_oversample();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
